// File: rtl/key_conditioner_pkg.sv
// Shared types and timing constants for the push-button front-end.
// Holds the FSM state encoding, board and simulation timing sets, and a width helper.
package key_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } key_state_t;

  // 100 MHz board timing: 10 ms debounce, 500 ms hold, 100 ms repeat period
  localparam int DEF_DEB_CYCLES  = 1000000;
  localparam int DEF_HOLD_CYCLES = 50000000;
  localparam int DEF_RPT_CYCLES  = 10000000;

  localparam int SIM_DEB_CYCLES  = 4;
  localparam int SIM_HOLD_CYCLES = 10;
  localparam int SIM_RPT_CYCLES  = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_conditioner_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs (keys, switches).
// Both stages clear on the synchronous reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: synchronizer, debounce FSM and hold-to-auto-repeat.
// Produces a debounced level plus one-cycle press, release and repeat strobes.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int RPT_CYCLES  = DEF_RPT_CYCLES,
  parameter int RPT_EN      = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic lvl_o,
  output logic ondn_o,
  output logic onup_o,
  output logic rpt_o
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic       w_btn_s;
  key_state_t r_state;
  logic [DEB_W-1:0] r_deb_cnt;
  logic       r_lvl;
  logic       r_ondn;
  logic       r_onup;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (btn_i),
    .q_o   (w_btn_s)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_deb_cnt <= '0;
      r_lvl     <= 1'b0;
      r_ondn    <= 1'b0;
      r_onup    <= 1'b0;
    end else begin
      r_ondn <= 1'b0;
      r_onup <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_btn_s) begin
            r_state   <= DB_PRESS;
            r_deb_cnt <= '0;
          end
        end
        DB_PRESS: begin
          if (!w_btn_s) begin
            r_state   <= IDLE;
            r_deb_cnt <= '0;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_state   <= HELD;
            r_deb_cnt <= '0;
            r_lvl     <= 1'b1;
            r_ondn    <= 1'b1;
          end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
          end
        end
        HELD: begin
          if (!w_btn_s) begin
            r_state   <= DB_REL;
            r_deb_cnt <= '0;
          end
        end
        DB_REL: begin
          if (w_btn_s) begin
            r_state   <= HELD;
            r_deb_cnt <= '0;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_state   <= IDLE;
            r_deb_cnt <= '0;
            r_lvl     <= 1'b0;
            r_onup    <= 1'b1;
          end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          r_deb_cnt <= '0;
        end
      endcase
    end
  end

  generate
    if (RPT_EN != 0) begin : g_rpt
      localparam int HOLD_W = $clog2(max_int(HOLD_CYCLES, RPT_CYCLES) + 1);
      localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
      localparam logic [HOLD_W-1:0] RPT_LAST  = HOLD_W'(RPT_CYCLES - 1);

      logic              w_enter_held;
      logic [HOLD_W-1:0] w_limit;
      logic [HOLD_W-1:0] r_hold_cnt;
      logic              r_first;
      logic              r_rpt;

      assign w_enter_held = (r_state == DB_PRESS) && w_btn_s && (r_deb_cnt == DEB_LAST);
      assign w_limit      = r_first ? HOLD_LAST : RPT_LAST;

      // A due pulse on a cycle that is leaving HELD is deferred, not dropped,
      // so rpt_o is never seen in DB_REL and the count never wraps.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_hold_cnt <= '0;
          r_first    <= 1'b1;
          r_rpt      <= 1'b0;
        end else begin
          r_rpt <= 1'b0;
          if (w_enter_held) begin
            r_hold_cnt <= '0;
            r_first    <= 1'b1;
          end else if (r_state == HELD) begin
            if (r_hold_cnt == w_limit) begin
              if (w_btn_s) begin
                r_rpt      <= 1'b1;
                r_hold_cnt <= '0;
                r_first    <= 1'b0;
              end
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
          end
        end
      end

      assign rpt_o = r_rpt;
    end else begin : g_no_rpt
      assign rpt_o = 1'b0;
    end
  endgenerate

  assign lvl_o  = r_lvl;
  assign ondn_o = r_ondn;
  assign onup_o = r_onup;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with short simulation timing.
// Vector table, hand-written corner sequences and random stimulus against a run-length model.
module tb_key_conditioner;
  import key_conditioner_pkg::*;

  localparam int DEB  = SIM_DEB_CYCLES;
  localparam int HOLD = SIM_HOLD_CYCLES;
  localparam int RPT  = SIM_RPT_CYCLES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic lvl, ondn, onup, rpt;
  logic lvl2, ondn2, onup2, rpt2;

  int checks   = 0;
  int failures = 0;

  // Model: sync pipe, accepted level, run of samples disagreeing with it,
  // and cycles since the last repeat reference point.
  bit m_s1, m_s2, m_lvl;
  int m_run, m_since, m_period;
  bit e_ondn, e_onup, e_rpt;

  typedef struct {
    bit b;
    bit r;
    bit lvl;
    bit ondn;
    bit onup;
    bit rpt;
  } vec_t;
  vec_t tbl[$];

  key_conditioner #(
    .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT), .RPT_EN(1)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .btn_i(btn),
    .lvl_o(lvl), .ondn_o(ondn), .onup_o(onup), .rpt_o(rpt)
  );

  key_conditioner #(
    .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT), .RPT_EN(0)
  ) u_dut_norpt (
    .clk_i(clk), .rst_i(rst), .btn_i(btn),
    .lvl_o(lvl2), .ondn_o(ondn2), .onup_o(onup2), .rpt_o(rpt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit b, input bit r);
    bit bs;
    bit held;
    e_ondn = 0; e_onup = 0; e_rpt = 0;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0;
      m_run = 0; m_since = 0; m_period = HOLD;
    end else begin
      bs   = m_s2;
      held = m_lvl && (m_run == 0);
      if (held) begin
        if (bs) begin
          m_since++;
          if (m_since == m_period) begin
            e_rpt = 1; m_since = 0; m_period = RPT;
          end
        end else if (m_since + 1 < m_period) begin
          m_since++;
        end
      end
      // A level change is accepted after DEB+1 consecutive disagreeing samples.
      if (bs != m_lvl) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_lvl = bs; m_run = 0;
          if (bs) begin
            e_ondn = 1; m_since = 0; m_period = HOLD;
          end else begin
            e_onup = 1;
          end
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
  endtask

  task automatic cycle(input bit b, input bit r);
    btn = b;
    rst = r;
    @(posedge clk);
    #1;
    model_step(b, r);
    chk("lvl", lvl, m_lvl);
    chk("ondn", ondn, e_ondn);
    chk("onup", onup, e_onup);
    chk("rpt", rpt, e_rpt);
    chk("norpt_lvl", lvl2, m_lvl);
    chk("norpt_ondn", ondn2, e_ondn);
    chk("norpt_onup", onup2, e_onup);
    chk("norpt_rpt", rpt2, 1'b0);
    $display("cyc b=%0b r=%0b lvl=%0b dn=%0b up=%0b rpt=%0b", b, r, lvl, ondn, onup, rpt);
  endtask

  function automatic vec_t mk(bit b, bit r, bit l, bit dn, bit up, bit rp);
    vec_t v;
    v.b = b; v.r = r; v.lvl = l; v.ondn = dn; v.onup = up; v.rpt = rp;
    return v;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic long_hold(input bit bounce);
    int got[$];
    int expd[$];
    bit seen = 0;
    idle(10);
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b1, 1'b0);
      seen = (ondn === 1'b1);
    end
    chk("hold_press_seen", seen, 1'b1);
    for (int hc = 1; hc <= 30; hc++) begin
      cycle((bounce && hc == 12) ? 1'b0 : 1'b1, 1'b0);
      if (rpt2 === 1'b1) got.push_back(-hc);
      if (rpt === 1'b1) got.push_back(hc);
    end
    if (bounce) expd = '{10, 13, 17, 20, 23, 26, 29};
    else        expd = '{10, 13, 16, 19, 22, 25, 28};
    chk_int("rpt_count", got.size(), expd.size());
    for (int i = 0; i < expd.size() && i < got.size(); i++)
      chk_int("rpt_at", got[i], expd[i]);
    idle(12);
  endtask

  task automatic press_after_reset(input string name);
    int n = 0;
    bit seen = 0;
    cycle(1'b1, 1'b1);
    chk({name, "_rst_lvl"}, lvl, 1'b0);
    chk({name, "_rst_ondn"}, ondn, 1'b0);
    while (n < 20 && !seen) begin
      cycle(1'b1, 1'b0);
      n++;
      seen = (ondn === 1'b1);
    end
    chk_int({name, "_latency"}, n, 7);
  endtask

  initial begin
    int pulses;
    bit b;

    // Reset, clean press/release, then bounce
    tbl.push_back(mk(0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0));
    for (int i = 1; i <= 6; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0));
    for (int i = 9; i <= 14; i++) tbl.push_back(mk(0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      cycle(tbl[i].b, tbl[i].r);
      chk("tbl_lvl", lvl, tbl[i].lvl);
      chk("tbl_ondn", ondn, tbl[i].ondn);
      chk("tbl_onup", onup, tbl[i].onup);
      chk("tbl_rpt", rpt, tbl[i].rpt);
    end

    long_hold(1'b0);
    long_hold(1'b1);

    // Reset during DB_PRESS, then during HELD, with the button still down
    idle(10);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
    press_after_reset("rst_dbpress");
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    press_after_reset("rst_held");
    idle(12);

    // Reset on the cycle that would complete the press debounce
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    chk("simul_ondn", ondn, 1'b0);
    chk("simul_lvl", lvl, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0);
      if (ondn === 1'b1 || onup === 1'b1) pulses++;
    end
    chk_int("simul_no_pulse", pulses, 0);

    // Random segments of held levels with occasional reset
    for (int s = 0; s < 80; s++) begin
      b = 1'($urandom_range(0, 1));
      for (int i = 0; i < int'($urandom_range(1, 30)); i++)
        cycle(b, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
